// File: rtl/proc_core_if.sv
// Bundles the run request, instruction/immediate input and display outputs of proc_core.
// Purely combinational wiring; adds no latency.
// No backpressure: Run is simply ignored while an instruction is in flight.
interface proc_core_if;
    logic       Run;
    logic [9:0] DIN;
    logic       Done;
    logic [9:0] BusWires;
    logic [9:0] R0;
    logic [9:0] R1;
    logic [9:0] R2;

    // Stimulus side: drives Run/DIN and observes the processor outputs
    modport master (
        output Run,
        output DIN,
        input  Done,
        input  BusWires,
        input  R0,
        input  R1,
        input  R2
    );

    // Processor side
    modport slave (
        input  Run,
        input  DIN,
        output Done,
        output BusWires,
        output R0,
        output R1,
        output R2
    );
endinterface

// File: rtl/proc_core.sv
// 10-bit multi-cycle register processor: 8 registers, shared bus, mv/mvi/add/sub/and.
// Latency: mv/mvi/nop write 2 edges after Run is sampled, ALU ops 4 edges after.
// Backpressure: Run is sampled only in T0; it is ignored while T1-T3 are in progress.
module proc_core (
    input  logic        Clock,
    input  logic        Reset,
    proc_core_if.slave  io
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [3:0] OP_MV  = 4'b0000;
    localparam logic [3:0] OP_MVI = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;

    logic [1:0] step_q, step_d;
    logic [9:0] ir_q, ir_d;
    logic [9:0] a_q, a_d;
    logic [9:0] g_q, g_d;
    logic [9:0] regs_q [8];

    logic [3:0] opcode;
    logic [2:0] rx_idx;
    logic [2:0] ry_idx;
    logic [9:0] bus;
    logic       done;
    logic       rf_we;

    assign opcode = ir_q[9:6];
    assign rx_idx = ir_q[5:3];
    assign ry_idx = ir_q[2:0];

    // Step sequencer: selects the bus source, the next step and which register loads
    always_comb begin
        step_d = step_q;
        ir_d   = ir_q;
        a_d    = a_q;
        g_d    = g_q;
        bus    = io.DIN;
        done   = 1'b0;
        rf_we  = 1'b0;
        case (step_q)
            T0: begin
                if (io.Run) begin
                    ir_d   = io.DIN;
                    step_d = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus    = regs_q[ry_idx];
                        rf_we  = 1'b1;
                        done   = 1'b1;
                        step_d = T0;
                    end
                    OP_MVI: begin
                        bus    = io.DIN;
                        rf_we  = 1'b1;
                        done   = 1'b1;
                        step_d = T0;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus    = regs_q[rx_idx];
                        a_d    = bus;
                        step_d = T2;
                    end
                    default: begin
                        // Unused opcodes retire immediately without touching registers
                        done   = 1'b1;
                        step_d = T0;
                    end
                endcase
            end
            T2: begin
                bus = regs_q[ry_idx];
                case (opcode)
                    OP_ADD:  g_d = a_q + bus;
                    OP_SUB:  g_d = a_q + ~bus + 10'd1;
                    default: g_d = a_q & bus;
                endcase
                step_d = T3;
            end
            default: begin
                bus    = g_q;
                rf_we  = 1'b1;
                done   = 1'b1;
                step_d = T0;
            end
        endcase
    end

    // State and register-file update; reset clears everything so an aborted op leaves no trace
    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_q <= T0;
            ir_q   <= '0;
            a_q    <= '0;
            g_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
            a_q    <= a_d;
            g_q    <= g_d;
            if (rf_we) begin
                regs_q[rx_idx] <= bus;
            end
        end
    end

    assign io.Done     = done;
    assign io.BusWires = bus;
    assign io.R0       = regs_q[0];
    assign io.R1       = regs_q[1];
    assign io.R2       = regs_q[2];

endmodule

// File: tb/tb_proc_core.sv
// Self-checking bench for proc_core: directed scenarios followed by random instructions.
// Outputs are sampled 1-2 time units after each rising edge.
// Run is optionally held high to exercise back-to-back starts.
module tb_proc_core;

    logic Clock;
    logic Reset;
    proc_core_if io ();

    proc_core u_dut (
        .Clock (Clock),
        .Reset (Reset),
        .io    (io)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Architectural model: register contents only
    logic [9:0] m [8];

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_r0"}, io.R0, m[0]);
        chk({tag, "_r1"}, io.R1, m[1]);
        chk({tag, "_r2"}, io.R2, m[2]);
    endtask

    task automatic step_edge();
        @(posedge Clock);
        #1;
    endtask

    // Issue one instruction from T0 and check every step until back in T0
    task automatic exec(input logic [9:0] instr, input logic [9:0] imm, input bit hold);
        int op, x, y;
        logic [9:0] rx, ry, res;
        op = int'(instr[9:6]);
        x  = int'(instr[5:3]);
        y  = int'(instr[2:0]);
        rx = m[x];
        ry = m[y];
        io.Run = 1'b1;
        io.DIN = instr;
        #1;
        chk("t0_done", 10'(io.Done), 10'd0);
        chk("t0_bus", io.BusWires, instr);
        step_edge();
        io.Run = hold;
        io.DIN = (op == 1) ? imm : 10'($urandom_range(0, 1023));
        #1;
        if (op == 0 || op == 1 || op >= 5) begin
            chk("t1_done", 10'(io.Done), 10'd1);
            chk("t1_bus", io.BusWires, (op == 0) ? ry : io.DIN);
            chk_regs("t1_hold");
            step_edge();
            if (op == 0) m[x] = ry;
            if (op == 1) m[x] = imm;
            chk_regs("short_wr");
        end else begin
            chk("t1_done", 10'(io.Done), 10'd0);
            chk("t1_bus", io.BusWires, rx);
            step_edge();
            io.DIN = 10'($urandom_range(0, 1023));
            #1;
            chk("t2_done", 10'(io.Done), 10'd0);
            chk("t2_bus", io.BusWires, ry);
            chk_regs("t2_hold");
            case (op)
                2:       res = 10'((int'(rx) + int'(ry)) % 1024);
                3:       res = 10'((int'(rx) - int'(ry) + 1024) % 1024);
                default: res = rx & ry;
            endcase
            step_edge();
            io.DIN = 10'($urandom_range(0, 1023));
            #1;
            chk("t3_done", 10'(io.Done), 10'd1);
            chk("t3_bus", io.BusWires, res);
            chk_regs("t3_hold");
            step_edge();
            m[x] = res;
            chk_regs("alu_wr");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, required finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) m[i] = '0;

        // Reset held 2 cycles with Run and DIN active
        Reset  = 1'b1;
        io.Run = 1'b1;
        io.DIN = 10'h3FF;
        for (int i = 0; i < 2; i++) begin
            step_edge();
            chk("rst_done", 10'(io.Done), 10'd0);
            chk_regs("rst");
            chk("rst_bus", io.BusWires, 10'h3FF);
        end
        Reset  = 1'b0;
        io.Run = 1'b0;
        step_edge();
        chk("post_rst_done", 10'(io.Done), 10'd0);
        chk("post_rst_bus", io.BusWires, 10'h3FF);

        // Directed: mvi, add wrap, sub underflow, mv, nop
        exec(10'h040, 10'h155, 1'b0);
        exec(10'h048, 10'h2AB, 1'b0);
        exec(10'h081, 10'h000, 1'b0);
        chk("add_wrap", io.R0, 10'h000);
        exec(10'h040, 10'h003, 1'b0);
        exec(10'h048, 10'h005, 1'b0);
        exec(10'h0C1, 10'h000, 1'b0);
        chk("sub_under", io.R0, 10'h3FE);
        exec(10'h010, 10'h000, 1'b0);
        chk("mv_r2", io.R2, 10'h3FE);
        exec(10'h3C0, 10'h000, 1'b1);
        // Aliasing
        exec(10'h05B, 10'h0F1, 1'b1);
        exec(10'h09B, 10'h000, 1'b1);
        exec(10'h01B, 10'h000, 1'b0);
        exec(10'h0DB, 10'h000, 1'b0);

        // Random instructions
        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15))
                                             : 4'($urandom_range(0, 4));
            exec({op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))},
                 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
        end

        // Held Run through add, DIN changes mid-flight, then reset in T2
        io.Run = 1'b1;
        io.DIN = 10'h081;
        step_edge();
        io.DIN = 10'h3C0;
        #1;
        chk("busy_t1_bus", io.BusWires, m[0]);
        chk("busy_t1_done", 10'(io.Done), 10'd0);
        step_edge();
        io.DIN = 10'h040;
        #1;
        chk("busy_t2_bus", io.BusWires, m[1]);
        chk("busy_t2_done", 10'(io.Done), 10'd0);
        Reset = 1'b1;
        step_edge();
        for (int i = 0; i < 8; i++) m[i] = '0;
        chk("midrst_done", 10'(io.Done), 10'd0);
        chk_regs("midrst");
        chk("midrst_bus", io.BusWires, 10'h040);
        Reset  = 1'b0;
        io.Run = 1'b0;
        step_edge();
        chk("midrst_after_done", 10'(io.Done), 10'd0);
        chk_regs("midrst_after");
        exec(10'h050, 10'h123, 1'b0);
        chk("final_mvi", io.R2, 10'h123);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
